// File: rtl/window_stream_gen_if.sv
// Ready/valid stream bundle; the master drives data/valid and the slave drives ready.
interface window_stream_gen_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/window_stream_gen.sv
// K x K multi-channel sliding-window generator with run-time K/W/H/stride and ready/valid on
// both streams. Define WSG_WINDOW_COUNT_EN to add the 16-bit window_count_out frame counter.
module window_stream_gen #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned CHANNELS        = 1,
    parameter int unsigned MAX_IMG_WIDTH   = 32,
    parameter int unsigned MAX_KERNEL_SIZE = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          cfg_kernel_size_in,
    input  logic [11:0]         cfg_img_width_in,
    input  logic [11:0]         cfg_img_height_in,
    input  logic [1:0]          cfg_stride_in,
    input  logic                start_in,
    window_stream_gen_if.slave  pix,
    window_stream_gen_if.master win,
    output logic                frame_done_out,
    output logic                cfg_err_out
`ifdef WSG_WINDOW_COUNT_EN
    ,
    output logic [15:0]         window_count_out
`endif
);
    localparam int unsigned MK  = MAX_KERNEL_SIZE;
    localparam int unsigned MK2 = MK * MK;
    localparam int unsigned AW  = (MAX_IMG_WIDTH > 1) ? $clog2(MAX_IMG_WIDTH) : 1;
    localparam int unsigned WW  = CHANNELS * MK2 * DATA_WIDTH;

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;
    state_e state_q, state_d;

    logic [2:0]  k_q;
    logic [11:0] w_q, h_q;
    logic [1:0]  s_q;
    logic [11:0] x_q, y_q;
    logic [1:0]  xph_q, yph_q;
    logic        all_in_q, cfg_err_q, wv_q;
    logic [WW-1:0] wout_q, wout_d;

    logic [DATA_WIDTH-1:0] win_q [CHANNELS][MK][MK];
    logic [DATA_WIDTH-1:0] win_d [CHANNELS][MK][MK];
    logic [DATA_WIDTH-1:0] lb_q  [CHANNELS][MK-1][MAX_IMG_WIDTH];

    logic        cfg_ok, start_ok, accept, x_last, y_last, last_beat, emit, load, win_hs;
    logic [11:0] km1;
    logic [31:0] k32;
    logic [AW-1:0] xa;

    assign cfg_ok = (cfg_kernel_size_in != 3'd0)
        && ({29'd0, cfg_kernel_size_in} <= MK)
        && (cfg_img_width_in >= {9'd0, cfg_kernel_size_in})
        && ({20'd0, cfg_img_width_in} <= MAX_IMG_WIDTH)
        && (cfg_img_height_in >= {9'd0, cfg_kernel_size_in})
        && (cfg_stride_in != 2'd0);

    assign k32       = {29'd0, k_q};
    assign km1       = {9'd0, k_q} - 12'd1;
    assign xa        = x_q[AW-1:0];
    assign start_ok  = (state_q == StIdle) && start_in && cfg_ok;
    assign accept    = pix.valid && pix.ready;
    assign x_last    = (x_q == w_q - 12'd1);
    assign y_last    = (y_q == h_q - 12'd1);
    assign last_beat = x_last && y_last;
    // Phases track (x-K+1) mod S and (y-K+1) mod S; only meaningful once x, y >= K-1.
    assign emit      = (x_q >= km1) && (y_q >= km1) && (xph_q == 2'd0) && (yph_q == 2'd0);
    assign load      = accept && emit;
    assign win_hs    = wv_q && win.ready;

    assign win.valid   = wv_q;
    assign win.data    = wout_q;
    assign cfg_err_out = cfg_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) state_d = StStream;
            end
            StStream: begin
                if ((all_in_q || (accept && last_beat && !emit)) && (!wv_q || win.ready)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pix.ready      = (state_q == StStream) && !all_in_q && (!wv_q || win.ready);
        frame_done_out = (state_q == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q       <= 3'd0;
            w_q       <= 12'd0;
            h_q       <= 12'd0;
            s_q       <= 2'd0;
            x_q       <= 12'd0;
            y_q       <= 12'd0;
            xph_q     <= 2'd0;
            yph_q     <= 2'd0;
            all_in_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            wv_q      <= 1'b0;
            wout_q    <= '0;
        end else begin
            cfg_err_q <= (state_q == StIdle) && start_in && !cfg_ok;
            if (start_ok) begin
                k_q      <= cfg_kernel_size_in;
                w_q      <= cfg_img_width_in;
                h_q      <= cfg_img_height_in;
                s_q      <= cfg_stride_in;
                x_q      <= 12'd0;
                y_q      <= 12'd0;
                xph_q    <= 2'd0;
                yph_q    <= 2'd0;
                all_in_q <= 1'b0;
            end else if (accept) begin
                if (x_last) begin
                    x_q   <= 12'd0;
                    xph_q <= 2'd0;
                    y_q   <= y_q + 12'd1;
                    if (y_q >= km1) begin
                        yph_q <= (yph_q == s_q - 2'd1) ? 2'd0 : yph_q + 2'd1;
                    end else begin
                        yph_q <= 2'd0;
                    end
                    if (y_last) all_in_q <= 1'b1;
                end else begin
                    x_q <= x_q + 12'd1;
                    if (x_q >= km1) begin
                        xph_q <= (xph_q == s_q - 2'd1) ? 2'd0 : xph_q + 2'd1;
                    end else begin
                        xph_q <= 2'd0;
                    end
                end
            end
            // Accept implies the old window is gone, so a load may replace it without a bubble.
            if (load) begin
                wv_q   <= 1'b1;
                wout_q <= wout_d;
            end else if (win_hs) begin
                wv_q <= 1'b0;
            end
        end
    end

    // Line buffers form a chain of rows: lb[MK-2] holds row y-1, lb[0] the oldest row.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                for (int unsigned i = 0; i + 2 < MK; i++) begin
                    lb_q[ch][i][xa] <= lb_q[ch][i+1][xa];
                end
                lb_q[ch][MK-2][xa] <= pix.data[ch*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                for (int unsigned r = 0; r < MK; r++) begin
                    for (int unsigned c = 0; c + 1 < MK; c++) begin
                        win_d[ch][r][c] = win_q[ch][r][c+1];
                    end
                end
                for (int unsigned r = 0; r + 1 < MK; r++) begin
                    win_d[ch][r][MK-1] = lb_q[ch][r][xa];
                end
                win_d[ch][MK-1][MK-1] = pix.data[ch*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The live K x K window is the bottom-right corner of the MK x MK register array.
    always_comb begin
        wout_d = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            for (int unsigned r = 0; r < MK; r++) begin
                for (int unsigned c = 0; c < MK; c++) begin
                    if ((r < k32) && (c < k32)) begin
                        wout_d[(ch*MK2 + r*k32 + c)*DATA_WIDTH +: DATA_WIDTH] =
                            win_d[ch][MK-k32+r][MK-k32+c];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                for (int unsigned r = 0; r < MK; r++) begin
                    for (int unsigned c = 0; c < MK; c++) begin
                        win_q[ch][r][c] <= '0;
                    end
                end
            end
        end else begin
            win_q <= win_d;
        end
    end

`ifdef WSG_WINDOW_COUNT_EN
    logic [15:0] wcnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q <= 16'd0;
        end else if (start_ok) begin
            wcnt_q <= 16'd0;
        end else if (win_hs) begin
            wcnt_q <= wcnt_q + 16'd1;
        end
    end

    assign window_count_out = wcnt_q;
`endif
endmodule

// File: tb/tb_window_stream_gen.sv
// Directed bench for window_stream_gen: table of frame configs with hand-computed windows,
// plus config-error, back-pressure and mid-frame reset sequences.
module tb_window_stream_gen;
    localparam int DW  = 8;
    localparam int CH  = 2;
    localparam int MIW = 32;
    localparam int MK  = 7;
    localparam int MK2 = MK * MK;
    localparam int WW  = CH * MK2 * DW;

    typedef struct packed {
        int          k;
        int          w;
        int          h;
        int          s;
        int          stall_at;
        int          stall_len;
        int          exp_windows;
        logic [71:0] first0;
        logic [71:0] first1;
        logic [71:0] second0;
        logic [71:0] last0;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  cfg_k;
    logic [11:0] cfg_w, cfg_h;
    logic [1:0]  cfg_s;
    logic        start;
    logic        frame_done, cfg_err;
`ifdef WSG_WINDOW_COUNT_EN
    logic [15:0] window_count;
`endif

    window_stream_gen_if #(.WIDTH(CH * DW)) pix_if ();
    window_stream_gen_if #(.WIDTH(WW))      win_if ();

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs [4];

    always #5 clk = ~clk;

    window_stream_gen #(
        .DATA_WIDTH     (DW),
        .CHANNELS       (CH),
        .MAX_IMG_WIDTH  (MIW),
        .MAX_KERNEL_SIZE(MK)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_kernel_size_in(cfg_k),
        .cfg_img_width_in  (cfg_w),
        .cfg_img_height_in (cfg_h),
        .cfg_stride_in     (cfg_s),
        .start_in          (start),
        .pix               (pix_if),
        .win               (win_if),
        .frame_done_out    (frame_done),
        .cfg_err_out       (cfg_err)
`ifdef WSG_WINDOW_COUNT_EN
        ,
        .window_count_out  (window_count)
`endif
    );

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_win(input string name, input logic [WW-1:0] act,
                             input logic [WW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [CH*DW-1:0] pix_val(input int idx);
        logic [CH*DW-1:0] v;
        for (int ch = 0; ch < CH; ch++) v[ch*DW +: DW] = 8'(idx + 1 + 100 * ch);
        return v;
    endfunction

    // Expected window n, derived from its top-left pixel coordinate.
    function automatic logic [WW-1:0] model_win(input int k, input int w, input int s,
                                                input int n);
        int nwx, wx, wy;
        logic [WW-1:0] v;
        nwx = (w - k) / s + 1;
        wx  = (n % nwx) * s;
        wy  = (n / nwx) * s;
        v   = '0;
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < k; r++)
                for (int c = 0; c < k; c++)
                    v[(ch*MK2 + r*k + c)*DW +: DW] = 8'((wy + r) * w + wx + c + 1 + 100 * ch);
        return v;
    endfunction

    task automatic start_frame(input int k, input int w, input int h, input int s);
        cfg_k = 3'(k);
        cfg_w = 12'(w);
        cfg_h = 12'(h);
        cfg_s = 2'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble config: the frame must keep using the latched values.
        cfg_k = 3'd0;
        cfg_w = 12'd1;
        cfg_h = 12'd1;
        cfg_s = 2'd0;
    endtask

    task automatic cfg_err_case(input string name, input int k, input int w, input int h,
                                input int s);
        cfg_k = 3'(k);
        cfg_w = 12'(w);
        cfg_h = 12'(h);
        cfg_s = 2'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_err_pulse"}, 72'(cfg_err), 72'd1);
        check({name, "_ready0"}, 72'(pix_if.ready), 72'd0);
        @(negedge clk);
        check({name, "_err_clear"}, 72'(cfg_err), 72'd0);
        check({name, "_ready1"}, 72'(pix_if.ready), 72'd0);
    endtask

    task automatic run_frame(input vec_t v, input int id);
        int pidx, nwin, cyc, stall_cnt, err_seen;
        int beat_last, hs_last, emit_beat, first_valid, done_cyc;
        int total, nexp, first_emit;
        logic [WW-1:0] held;
        string tag;
        pidx = 0; nwin = 0; cyc = 0; stall_cnt = 0; err_seen = 0;
        beat_last = -1; hs_last = -1; emit_beat = -1; first_valid = -1; done_cyc = -1;
        total      = v.w * v.h;
        nexp       = ((v.w - v.k) / v.s + 1) * ((v.h - v.k) / v.s + 1);
        first_emit = (v.k - 1) * v.w + (v.k - 1);
        held       = '0;
        tag        = $sformatf("v%0d", id);
        start_frame(v.k, v.w, v.h, v.s);
        while (cyc < 3000) begin
            pix_if.valid = (pidx < total);
            pix_if.data  = pix_val(pidx);
            win_if.ready = !(win_if.valid && nwin == v.stall_at && stall_cnt < v.stall_len);
            start        = (cyc == 3);
            #1;
            if (cfg_err) err_seen++;
            if (frame_done) begin
                done_cyc = cyc;
                break;
            end
            if (win_if.valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (!win_if.ready) begin
                    if (stall_cnt == 0) held = win_if.data;
                    else check_win($sformatf("%s_stall_hold%0d", tag, stall_cnt),
                                   win_if.data, held);
                    check($sformatf("%s_stall_ready%0d", tag, stall_cnt),
                          72'(pix_if.ready), 72'd0);
                    stall_cnt++;
                end else begin
                    check_win($sformatf("%s_win%0d", tag, nwin), win_if.data,
                              model_win(v.k, v.w, v.s, nwin));
                    if (nwin == 0) begin
                        check({tag, "_first_ch0"}, win_if.data[71:0], v.first0);
                        check({tag, "_first_ch1"}, win_if.data[MK2*DW +: 72], v.first1);
                    end
                    if (nwin == 1) check({tag, "_second_ch0"}, win_if.data[71:0], v.second0);
                    if (nwin == v.exp_windows - 1)
                        check({tag, "_last_ch0"}, win_if.data[71:0], v.last0);
                    nwin++;
                    hs_last = cyc;
                end
            end
            if (pix_if.valid && pix_if.ready) begin
                if (pidx == first_emit) emit_beat = cyc;
                beat_last = cyc;
                pidx++;
            end
            @(negedge clk);
            cyc++;
        end
        pix_if.valid = 1'b0;
        win_if.ready = 1'b1;
        start        = 1'b0;
        if (done_cyc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no frame_done required frame_done", tag);
            return;
        end
        check({tag, "_win_count"}, 72'(nwin), 72'(v.exp_windows));
        check({tag, "_model_count"}, 72'(nwin), 72'(nexp));
        check({tag, "_beats"}, 72'(pidx), 72'(total));
        check({tag, "_latency"}, 72'(first_valid), 72'(emit_beat + 1));
        check({tag, "_done_cycle"}, 72'(done_cyc),
              72'(((hs_last > beat_last) ? hs_last : beat_last) + 1));
        check({tag, "_no_cfg_err"}, 72'(err_seen), 72'd0);
        if (v.stall_len > 0) check({tag, "_stall_len"}, 72'(stall_cnt), 72'(v.stall_len));
`ifdef WSG_WINDOW_COUNT_EN
        check({tag, "_count_at_done"}, 72'(window_count), 72'(v.exp_windows));
`endif
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 72'(frame_done), 72'd0);
        check({tag, "_idle_ready"}, 72'(pix_if.ready), 72'd0);
    endtask

    initial begin
        int beats, guard;
        vecs[0] = '{k: 3, w: 6, h: 6, s: 1, stall_at: -1, stall_len: 0, exp_windows: 16,
                    first0: pack9(1, 2, 3, 7, 8, 9, 13, 14, 15),
                    first1: pack9(101, 102, 103, 107, 108, 109, 113, 114, 115),
                    second0: pack9(2, 3, 4, 8, 9, 10, 14, 15, 16),
                    last0: pack9(22, 23, 24, 28, 29, 30, 34, 35, 36)};
        vecs[1] = '{k: 3, w: 8, h: 8, s: 2, stall_at: -1, stall_len: 0, exp_windows: 9,
                    first0: pack9(1, 2, 3, 9, 10, 11, 17, 18, 19),
                    first1: pack9(101, 102, 103, 109, 110, 111, 117, 118, 119),
                    second0: pack9(3, 4, 5, 11, 12, 13, 19, 20, 21),
                    last0: pack9(37, 38, 39, 45, 46, 47, 53, 54, 55)};
        vecs[2] = '{k: 2, w: 4, h: 4, s: 1, stall_at: 2, stall_len: 5, exp_windows: 9,
                    first0: pack9(1, 2, 5, 6, 0, 0, 0, 0, 0),
                    first1: pack9(101, 102, 105, 106, 0, 0, 0, 0, 0),
                    second0: pack9(2, 3, 6, 7, 0, 0, 0, 0, 0),
                    last0: pack9(11, 12, 15, 16, 0, 0, 0, 0, 0)};
        vecs[3] = '{k: 1, w: 4, h: 3, s: 3, stall_at: -1, stall_len: 0, exp_windows: 2,
                    first0: pack9(1, 0, 0, 0, 0, 0, 0, 0, 0),
                    first1: pack9(101, 0, 0, 0, 0, 0, 0, 0, 0),
                    second0: pack9(4, 0, 0, 0, 0, 0, 0, 0, 0),
                    last0: pack9(4, 0, 0, 0, 0, 0, 0, 0, 0)};

        pix_if.valid = 1'b0;
        pix_if.data  = '0;
        win_if.ready = 1'b1;
        start        = 1'b0;
        cfg_k        = 3'd3;
        cfg_w        = 12'd6;
        cfg_h        = 12'd6;
        cfg_s        = 2'd1;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 72'(pix_if.ready), 72'd0);
        check("rst_valid", 72'(win_if.valid), 72'd0);
        check_win("rst_window", win_if.data, '0);
        check("rst_done", 72'(frame_done), 72'd0);
        check("rst_cfg_err", 72'(cfg_err), 72'd0);
        rst = 1'b0;
        @(negedge clk);

        cfg_err_case("k5_w4", 5, 4, 4, 1);
        cfg_err_case("k0", 0, 6, 6, 1);
        cfg_err_case("h_lt_k", 3, 6, 2, 1);
        cfg_err_case("s0", 3, 6, 6, 0);

        for (int i = 0; i < 4; i++) run_frame(vecs[i], i);

        // Abort a frame after a couple of windows have been loaded, then rerun it cleanly.
        start_frame(3, 6, 6, 1);
        pix_if.valid = 1'b1;
        beats = 0;
        guard = 0;
        while (beats < 16 && guard < 100) begin
            pix_if.data = pix_val(beats);
            #1;
            if (pix_if.ready) beats++;
            @(negedge clk);
            guard++;
        end
        check("abort_beats", 72'(beats), 72'd16);
        rst = 1'b1;
        #1;
        check("abort_ready", 72'(pix_if.ready), 72'd0);
        check("abort_valid", 72'(win_if.valid), 72'd0);
        check_win("abort_window", win_if.data, '0);
        check("abort_done", 72'(frame_done), 72'd0);
        pix_if.valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame(vecs[0], 4);
`ifdef WSG_WINDOW_COUNT_EN
        repeat (3) @(negedge clk);
        check("count_held", 72'(window_count), 72'd16);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
